xor_route_arbiter: RTL and testbench
====================================

Name: xor_route_arbiter

Overview:
- Shares one address-XOR routing stage among NREQ input ports of a NoC router.
- Each port presents a flit field and a destination address.
- The block grants one port per accept in round-robin order and computes data ^ addr. It registers the result with the source index and holds it on a valid/ready output until downstream takes it.
- Sits between the router input buffers and the route-compute/crossbar control.

Parameters:
- NREQ, 4, number of requesting ports (2..16).
- DW, 4, width of the data and address fields.
- SW, $clog2(NREQ), width of the source index (derived localparam, not overridable).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous assert, active-low reset.
- req_valid  in  NREQ  per-port request.
- req_data  in  NREQ*DW  per-port data field; port i occupies bits [i*DW +: DW].
- req_addr  in  NREQ*DW  per-port destination address, same packing.
- req_ready  out  NREQ  per-port accept; at most one bit set.
- out_valid  out  1  result register holds a valid entry.
- out_data  out  DW  registered data ^ addr of the granted port.
- out_src  out  SW  index of the granted port.
- out_ready  in  1  downstream accepts the result.
- busy  out  1  high in the HOLD state.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, rr_ptr=0.
  - out_valid=0, out_data=0, out_src=0, busy=0.
  - req_ready=0, held combinationally while reset_n is low.
- Reset mid-operation discards any held result. Requesters keep their valid asserted and are re-arbitrated after release.
- Handshake:
  - Transfer on port i when req_valid[i] & req_ready[i] in the same cycle.
  - Requesters hold valid, data and addr stable until accepted.
  - Output transfer when out_valid & out_ready.
- can_load = (state==IDLE) | (state==HOLD & out_ready).
- Grant (combinational):
  - If can_load and any req_valid, winner g = first index with req_valid set, scanning rr_ptr, rr_ptr+1, ..., wrapping at NREQ-1 to 0.
  - req_ready = one-hot(g); otherwise req_ready=0.
  - req_ready never depends on req_data or req_addr.
- On an accept (next edge):
  - out_data <= req_data[g] ^ req_addr[g] (bitwise, DW bits, no carry).
  - out_src <= g, out_valid <= 1, state <= HOLD.
  - rr_ptr <= (g==NREQ-1) ? 0 : g+1.
- FSM:
  - IDLE: wait for any request. An accept moves to HOLD; otherwise stay in IDLE.
  - HOLD with out_ready=0: out_valid, out_data and out_src remain stable and req_ready=0.
  - HOLD with out_ready=1 and an accept: reload, stay in HOLD.
  - HOLD with out_ready=1 and no request: out_valid <= 0, state <= IDLE.
- Latency and throughput:
  - Accept in cycle N gives out_valid in cycle N+1.
  - Sustained 1 result/cycle when out_ready is held high.
- Fairness: a continuously requesting port is granted within NREQ accepts.
- rr_ptr advances only on an accept, never on idle cycles.
- Simultaneous output drain and new accept in one cycle is legal and loses no result.

Optional Feature:
- Macro: XOR_ROUTE_ARBITER_STATS_EN.
- When defined, adds two ports:
  - stats_clr (in, 1): synchronous clear.
  - grant_cnt (out, NREQ*8): per-port 8-bit saturating accept counters, reset to 0.
- A counter increments on each accept of its port and saturates at 255.
- stats_clr zeroes all counters and takes priority over a same-cycle increment.
- When undefined: neither port exists, no counter logic, and behaviour is otherwise identical.

Decomposition:
- Package xor_route_pkg holds:
  - the state enum (IDLE, HOLD);
  - DW and NREQ defaults;
  - the stats counter width constant (8) and its saturation value.
- Sub-module rr_pick: combinational round-robin first-set finder (inputs: request vector, pointer; outputs: one-hot grant, index, any).
- The XOR stage and result register stay in the top module.

Test Plan:
- Reset with all req_valid=1 -> req_ready=0, out_valid=0. First edge after release grants port 0 and loads out_src=0.
- Single request: port 2, data=4'hA, addr=4'h3, out_ready=1 -> req_ready[2] high for one cycle; next cycle out_valid=1, out_data=4'h9, out_src=2.
- All 4 ports requesting continuously, out_ready=1 -> out_src sequence 0,1,2,3,0,..., one result per cycle.
- Backpressure: out_ready=0 for 5 cycles while holding a result -> out_data/out_src stable and req_ready=0 throughout. Raising out_ready drains and reloads in the same cycle.
- Wrap: rr_ptr=3, only ports 1 and 3 requesting -> grant 3 then 1; assert reset_n low during HOLD -> out_valid drops immediately.
- (XOR_ROUTE_ARBITER_STATS_EN) 300 accepts of port 1 -> grant_cnt[1]=255. stats_clr coincident with an accept -> count 0.

Source files
------------

// File: rtl/xor_route_pkg.sv
// Shared types and constants for the XOR routing arbiter.
// Holds the FSM state enum, default sizes, and the optional stats counter geometry.
package xor_route_pkg;

    // Default number of requesting ports and field width
    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned DW_DEF   = 4;

    // Per-port accept counter geometry (used only with XOR_ROUTE_ARBITER_STATS_EN)
    localparam int unsigned          STAT_W   = 8;
    localparam logic [STAT_W-1:0]    STAT_MAX = {STAT_W{1'b1}};

    // Arbiter FSM: IDLE waits for a request, HOLD owns a valid result
    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StHold = 1'b1
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-set finder.
// Scans req starting at ptr and wrapping at N-1 to 0; returns one-hot grant,
// its index, and whether any request was present.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int             j;
    logic [IW-1:0]  jx;

    // Walk the ring from ptr; the first set bit wins
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        jx  = '0;
        for (int k = 0; k < int'(N); k++) begin
            j = int'(ptr) + k;
            if (j >= int'(N)) begin
                j = j - int'(N);
            end
            jx = IW'(j);
            if (!any && req[jx]) begin
                any     = 1'b1;
                gnt[jx] = 1'b1;
                idx     = jx;
            end
        end
    end

endmodule

// File: rtl/xor_route_arbiter.sv
// Round-robin arbiter sharing one address-XOR routing stage among NREQ ports.
// The granted port's data ^ addr is registered with its source index and held
// on a valid/ready output until downstream takes it.
// Optional feature: define XOR_ROUTE_ARBITER_STATS_EN to add per-port
// saturating accept counters (stats_clr / grant_cnt ports).
module xor_route_arbiter
    import xor_route_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned DW   = DW_DEF,
    localparam int unsigned SW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ*DW-1:0] req_addr,
    output logic [NREQ-1:0]    req_ready,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    output logic [SW-1:0]      out_src,
    input  logic               out_ready,
    output logic               busy
`ifdef XOR_ROUTE_ARBITER_STATS_EN
    ,
    input  logic                   stats_clr,
    output logic [NREQ*STAT_W-1:0] grant_cnt
`endif
);

    state_e          state_q;
    logic [SW-1:0]   rr_ptr_q;
    logic [NREQ-1:0] gnt;
    logic [SW-1:0]   gnt_idx;
    logic            gnt_any;
    logic            can_load;
    logic            accept;
    logic [DW-1:0]   sel_xor;

    rr_pick #(
        .N  (NREQ),
        .IW (SW)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    // A new result may be loaded when empty or when the held one drains this cycle
    always_comb begin
        can_load  = (state_q == StIdle) || out_ready;
        accept    = reset_n && can_load && gnt_any;
        req_ready = (reset_n && can_load) ? gnt : '0;
    end

    // AND-OR mux of the per-port XOR, selected by the one-hot grant
    always_comb begin
        sel_xor = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt[i]) begin
                sel_xor = sel_xor | (req_data[i*DW +: DW] ^ req_addr[i*DW +: DW]);
            end
        end
    end

    // FSM with registered result; pointer moves only on an accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            rr_ptr_q  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (accept) begin
            state_q   <= StHold;
            out_valid <= 1'b1;
            out_data  <= sel_xor;
            out_src   <= gnt_idx;
            rr_ptr_q  <= (gnt_idx == SW'(NREQ - 1)) ? '0 : gnt_idx + SW'(1);
        end else if (state_q == StHold && out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
        end
    end

    // Busy simply reflects ownership of a result
    always_comb begin
        busy = (state_q == StHold);
    end

`ifdef XOR_ROUTE_ARBITER_STATS_EN
    logic [NREQ-1:0][STAT_W-1:0] cnt_q;

    // Per-port saturating accept counters; clear beats a same-cycle increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (stats_clr) begin
            cnt_q <= '0;
        end else if (accept) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (gnt[i] && cnt_q[i] != STAT_MAX) begin
                    cnt_q[i] <= cnt_q[i] + STAT_W'(1);
                end
            end
        end
    end

    // Flatten counters onto the output bus, port i at [i*STAT_W +: STAT_W]
    always_comb begin
        grant_cnt = cnt_q;
    end
`endif

endmodule

// File: tb/tb_xor_route_arbiter.sv
// Self-checking bench for xor_route_arbiter: directed phases plus random traffic,
// checked against a transaction-level model of the arbitration rules.
module tb_xor_route_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 4;
    localparam int SW   = 2;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ*DW-1:0] req_addr;
    logic [NREQ-1:0]    req_ready;
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic [SW-1:0]      out_src;
    logic               out_ready;
    logic               busy;
`ifdef XOR_ROUTE_ARBITER_STATS_EN
    logic               stats_clr;
    logic [NREQ*8-1:0]  grant_cnt;
`endif

    always #5 clk = ~clk;

    xor_route_arbiter #(
        .NREQ (NREQ),
        .DW   (DW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef XOR_ROUTE_ARBITER_STATS_EN
        ,
        .stats_clr (stats_clr),
        .grant_cnt (grant_cnt)
`endif
    );

    // Requester side: pending flag with stable data/addr until accepted
    bit            pend [NREQ];
    logic [DW-1:0] pd   [NREQ];
    logic [DW-1:0] pa   [NREQ];

    // Reference model state
    int            m_ptr;
    bit            m_valid;
    logic [DW-1:0] m_data;
    int            m_src;
    int            m_cnt [NREQ];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]          = pend[i];
            req_data[i*DW +: DW]  = pd[i];
            req_addr[i*DW +: DW]  = pa[i];
        end
    endtask

    task automatic raise(input int pct);
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && ($urandom % 100) < pct) begin
                pend[i] = 1'b1;
                pd[i]   = DW'($urandom);
                pa[i]   = DW'($urandom);
            end
        end
    endtask

    function automatic bit any_pend();
        bit r = 1'b0;
        for (int i = 0; i < NREQ; i++) r |= pend[i];
        return r;
    endfunction

    // Reset pulse: checks async clear, then releases away from the clock edge
    task automatic do_reset();
        reset_n = 1'b0;
        drive();
        #1;
        m_ptr   = 0;
        m_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        check("rst_req_ready", req_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_src", out_src, 0);
        @(posedge clk);
        #1;
        check("rst_hold_req_ready", req_ready, 0);
        reset_n = 1'b1;
    endtask

    // One clock: check combinational grant, advance model, check registered outputs
    task automatic step(input bit ordy, input bit clr);
        bit               can;
        int               g;
        int               j;
        logic [NREQ-1:0]  exp_rdy;
        logic [NREQ*8-1:0] ev;
        out_ready = ordy;
`ifdef XOR_ROUTE_ARBITER_STATS_EN
        stats_clr = clr;
`endif
        drive();
        #1;
        can = !m_valid || ordy;
        g   = -1;
        for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (g < 0 && pend[j]) g = j;
        end
        exp_rdy = '0;
        if (can && g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", req_ready, exp_rdy);
        @(posedge clk);
        if (clr) begin
            for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
        end else if (can && g >= 0 && m_cnt[g] < 255) begin
            m_cnt[g]++;
        end
        if (can && g >= 0) begin
            m_valid = 1'b1;
            m_data  = pd[g] ^ pa[g];
            m_src   = g;
            m_ptr   = (g + 1) % NREQ;
            pend[g] = 1'b0;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        #1;
        check("out_valid", out_valid, m_valid);
        check("busy", busy, m_valid);
        if (m_valid) begin
            check("out_data", out_data, m_data);
            check("out_src", out_src, m_src);
        end
`ifdef XOR_ROUTE_ARBITER_STATS_EN
        ev = '0;
        for (int i = 0; i < NREQ; i++) ev[i*8 +: 8] = 8'(m_cnt[i]);
        check("grant_cnt", grant_cnt, ev);
`else
        ev = '0;
        if (clr) ev = '1;
`endif
    endtask

    task automatic drain_all();
        for (int n = 0; n < 2 * NREQ && any_pend(); n++) step(1'b1, 1'b0);
        step(1'b1, 1'b0);
    endtask

    initial begin
        out_ready = 1'b0;
`ifdef XOR_ROUTE_ARBITER_STATS_EN
        stats_clr = 1'b0;
`endif
        // Reset with every port requesting; first grant goes to port 0
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b1;
            pd[i]   = DW'($urandom);
            pa[i]   = DW'($urandom);
        end
        do_reset();
        step(1'b1, 1'b0);
        check("first_src_port0", out_src, 0);
        drain_all();

        // Single request on port 2
        pend[2] = 1'b1;
        pd[2]   = 4'hA;
        pa[2]   = 4'h3;
        step(1'b1, 1'b0);
        check("single_xor", out_data, 4'h9);
        check("single_src", out_src, 2);
        step(1'b1, 1'b0);

        // All ports continuously requesting, one result per cycle
        for (int n = 0; n < 8; n++) begin
            raise(100);
            step(1'b1, 1'b0);
        end

        // Backpressure for 5 cycles, then drain and reload together
        raise(100);
        for (int n = 0; n < 5; n++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        drain_all();

        // Wrap: push pointer to 3, then ports 1 and 3 only
        pend[2] = 1'b1;
        pd[2]   = DW'($urandom);
        pa[2]   = DW'($urandom);
        step(1'b1, 1'b0);
        pend[1] = 1'b1;
        pd[1]   = DW'($urandom);
        pa[1]   = DW'($urandom);
        pend[3] = 1'b1;
        pd[3]   = DW'($urandom);
        pa[3]   = DW'($urandom);
        step(1'b1, 1'b0);
        check("wrap_first_src", out_src, 3);
        pend[2] = 1'b1;
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("wrap_second_src", out_src, 1);
        // Reset during HOLD drops the result immediately; requester 2 is re-arbitrated
        do_reset();
        step(1'b1, 1'b0);
        check("post_reset_src", out_src, 2);

        // Random traffic with random backpressure
        for (int n = 0; n < 300; n++) begin
            raise(40);
            step(($urandom % 4) != 0, 1'b0);
        end
        drain_all();

`ifdef XOR_ROUTE_ARBITER_STATS_EN
        // Saturation of port 1 counter, then clear against a coincident accept
        for (int n = 0; n < 300; n++) begin
            pend[1] = 1'b1;
            pd[1]   = DW'($urandom);
            pa[1]   = DW'($urandom);
            step(1'b1, 1'b0);
        end
        check("cnt1_saturated", grant_cnt[15:8], 255);
        pend[1] = 1'b1;
        step(1'b1, 1'b1);
        check("cnt1_cleared", grant_cnt[15:8], 0);
        step(1'b1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
